// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: command sequencer between a byte-level SPI slave shifter
// and a small register bank.
//
// Each chip-select frame starts with a command byte (bit 7 = read flag,
// low ADDR_W bits = start address), followed by data bytes. Write bytes
// commit one register each. Read data is fetched and handed to the shifter
// before the next byte shifts out. The address auto-increments when
// AUTO_INC is set.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   frame_active   synchronised chip-select level (1 = frame open)
//   rx_valid       1-cycle strobe, rx_byte holds a complete MOSI byte
//   rx_byte        received byte
//   tx_byte        byte for the shifter to send next
//   tx_load        1-cycle strobe, shifter latches tx_byte
//   reg_addr       register address
//   reg_wr_en      1-cycle write strobe, reg_wdata is the write data
//   reg_wdata      write data (0 when no write is in progress)
//   reg_rd_en      1-cycle read strobe, reg_rdata is valid one cycle later
//   reg_rdata      read data from the bank
//   err_ovr        sticky: a byte arrived while a read fetch was pending
//   byte_cnt       data bytes handled in this frame, saturating at 8'hFF
module spi_reg_ctrl #(
  parameter int         ADDR_W    = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         AUTO_INC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_active,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic              tx_load,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr_en,
  output logic [7:0]        reg_wdata,
  output logic              reg_rd_en,
  input  logic [7:0]        reg_rdata,
  output logic              err_ovr,
  output logic [7:0]        byte_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR,
    RD_FETCH,
    RD_LOAD,
    RD
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_STEP = (AUTO_INC != 0) ? ADDR_W'(1) : '0;

  state_t            state_reg, state_next;
  logic              fa_reg;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic              err_reg, err_next;
  logic [7:0]        tx_hold_reg;
  logic [7:0]        tx_val;
  logic              load;
  logic              wr;
  logic              rd;

  // fa_reg resets to 1 so that a frame already open when reset releases is
  // not joined half-way; only a clean 0->1 edge starts a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      fa_reg      <= 1'b1;
      addr_reg    <= '0;
      cnt_reg     <= 8'h00;
      err_reg     <= 1'b0;
      tx_hold_reg <= SYNC_BYTE;
    end else begin
      state_reg <= state_next;
      fa_reg    <= frame_active;
      addr_reg  <= addr_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      if (load) begin
        tx_hold_reg <= tx_val;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    tx_val     = tx_hold_reg;
    load       = 1'b0;
    wr         = 1'b0;
    rd         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (frame_active && !fa_reg) begin
          load       = 1'b1;
          tx_val     = SYNC_BYTE;
          err_next   = 1'b0;
          cnt_next   = 8'h00;
          state_next = CMD;
        end
      end
      CMD: begin
        if (rx_valid) begin
          addr_next  = rx_byte[ADDR_W-1:0];
          state_next = rx_byte[7] ? RD_FETCH : WR;
        end
      end
      WR: begin
        if (rx_valid) begin
          wr        = 1'b1;
          load      = 1'b1;
          tx_val    = rx_byte;
          addr_next = addr_reg + ADDR_STEP;
          cnt_next  = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;
        end
      end
      RD_FETCH: begin
        rd         = 1'b1;
        state_next = RD_LOAD;
        if (rx_valid) begin
          err_next = 1'b1;
        end
      end
      RD_LOAD: begin
        load       = 1'b1;
        tx_val     = reg_rdata;
        addr_next  = addr_reg + ADDR_STEP;
        state_next = RD;
        if (rx_valid) begin
          err_next = 1'b1;
        end
      end
      RD: begin
        if (rx_valid) begin
          cnt_next   = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;
          state_next = RD_FETCH;
        end
      end
      default: state_next = IDLE;
    endcase

    // Chip-select low closes the frame: this cycle's work (including a byte
    // arriving right now) still completes, but no new step is started.
    if (state_reg != IDLE && !frame_active) begin
      state_next = IDLE;
    end
  end

  assign tx_byte   = tx_val;
  assign tx_load   = load;
  assign reg_addr  = addr_reg;
  assign reg_wr_en = wr;
  assign reg_wdata = wr ? rx_byte : 8'h00;
  assign reg_rd_en = rd;
  assign err_ovr   = err_reg;
  assign byte_cnt  = cnt_reg;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed frames plus randomized frames. Each frame
// is planned as a per-cycle schedule; a frame-level model derives, from the
// byte timing, which cycles must carry write/read/load strobes and with what
// values. One compare process checks the DUT against that every cycle.
module tb_spi_reg_ctrl;

  localparam int NC = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_active;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic [3:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wdata;
  logic       reg_rd_en;
  logic [7:0] reg_rdata = 8'h00;
  logic       err_ovr;
  logic [7:0] byte_cnt;

  logic [7:0] fix_tx_byte;
  logic       fix_tx_load;
  logic [3:0] fix_addr;
  logic       fix_wr_en;
  logic [7:0] fix_wdata;
  logic       fix_rd_en;
  logic [7:0] fix_rdata = 8'h00;
  logic       fix_err;
  logic [7:0] fix_cnt;

  spi_reg_ctrl #(.ADDR_W(4), .SYNC_BYTE(8'hA5), .AUTO_INC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .frame_active(frame_active), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .tx_byte(tx_byte), .tx_load(tx_load), .reg_addr(reg_addr),
    .reg_wr_en(reg_wr_en), .reg_wdata(reg_wdata), .reg_rd_en(reg_rd_en),
    .reg_rdata(reg_rdata), .err_ovr(err_ovr), .byte_cnt(byte_cnt)
  );

  spi_reg_ctrl #(.ADDR_W(4), .SYNC_BYTE(8'hA5), .AUTO_INC(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .frame_active(frame_active), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .tx_byte(fix_tx_byte), .tx_load(fix_tx_load), .reg_addr(fix_addr),
    .reg_wr_en(fix_wr_en), .reg_wdata(fix_wdata), .reg_rd_en(fix_rd_en),
    .reg_rdata(fix_rdata), .err_ovr(fix_err), .byte_cnt(fix_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stimulus schedule
  bit       st_rst[NC];
  bit       st_fa[NC];
  bit       st_rv[NC];
  bit [7:0] st_rb[NC];
  // expectations
  bit       exp_wr[NC];
  bit [3:0] exp_wa[NC];
  bit [7:0] exp_wd[NC];
  bit       exp_rd[NC];
  bit [3:0] exp_ra[NC];
  bit       exp_ld[NC];
  bit [7:0] exp_tx[NC];
  bit       chk_st[NC];
  bit [7:0] exp_cnt[NC];
  bit       exp_err[NC];
  bit       exp_rst[NC];

  // register bank seen by the DUT, and the model's own copy
  bit [7:0] mem[16];
  bit [7:0] model_mem[16];
  bit       pre_en = 1'b0;
  bit [3:0] pre_a  = 4'h0;
  bit [7:0] pre_d  = 8'h00;

  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (reg_wr_en) mem[reg_addr] <= reg_wdata;
    if (reg_rd_en) reg_rdata <= mem[reg_addr];
  end

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int fix_wr = 0;
  int fix_wr7 = 0;
  bit [7:0] tx_log[$];

  bit [7:0] fdat[8];
  int       fgap[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int c;
    c = cyc;
    if (c >= 1 && c < NC) begin
      chk("wr_en", 32'(reg_wr_en), 32'(exp_wr[c]));
      chk("rd_en", 32'(reg_rd_en), 32'(exp_rd[c]));
      chk("tx_load", 32'(tx_load), 32'(exp_ld[c]));
      if (exp_wr[c]) begin
        chk("wr_addr", 32'(reg_addr), 32'(exp_wa[c]));
        chk("wr_data", 32'(reg_wdata), 32'(exp_wd[c]));
      end
      if (exp_rd[c]) chk("rd_addr", 32'(reg_addr), 32'(exp_ra[c]));
      if (exp_ld[c]) chk("tx_byte", 32'(tx_byte), 32'(exp_tx[c]));
      if (chk_st[c]) begin
        chk("byte_cnt", 32'(byte_cnt), 32'(exp_cnt[c]));
        chk("err_ovr", 32'(err_ovr), 32'(exp_err[c]));
      end
      if (exp_rst[c]) begin
        chk("rst_tx_byte", 32'(tx_byte), 32'h0000_00A5);
        chk("rst_addr", 32'(reg_addr), 32'h0);
        chk("rst_wdata", 32'(reg_wdata), 32'h0);
      end
    end
    if (reg_wr_en) wr_cnt <= wr_cnt + 1;
    if (reg_rd_en) rd_cnt <= rd_cnt + 1;
    if (tx_load) tx_log.push_back(tx_byte);
    if (fix_wr_en) begin
      fix_wr <= fix_wr + 1;
      if (fix_addr == 4'h7) fix_wr7 <= fix_wr7 + 1;
    end
  end

  task automatic step_to(input int last);
    while (cyc < last) begin
      @(posedge clk);
      #1;
      rst_n        = !st_rst[cyc];
      frame_active = st_fa[cyc];
      rx_valid     = st_rv[cyc];
      rx_byte      = st_rb[cyc];
    end
  endtask

  task automatic preload(input bit [3:0] a, input bit [7:0] d);
    pre_a = a;
    pre_d = d;
    pre_en = 1'b1;
    model_mem[a] = d;
    step_to(cyc + 1);
    pre_en = 1'b0;
  endtask

  // Plan one frame (command + n data bytes, gaps from fgap, data from fdat),
  // derive the expected strobes, then drive it. rst_off > 0 asserts reset
  // that many cycles after the frame opens.
  task automatic do_frame(input bit [7:0] cmd, input int n, input int close_gap, input int rst_off);
    int base, s, e, r, fin, c, t, a, cnt, i;
    bit err;
    int bc[8];
    base = cyc + 1;
    s = base + 1;
    c = s;
    for (int k = 0; k <= n; k++) begin
      c += fgap[k];
      bc[k] = c;
    end
    e = bc[n] + close_gap;
    fin = e + 3;
    if (fin + 2 >= NC) begin
      $display("FAIL schedule cyc=%0d got=%0d want<%0d", cyc, fin, NC);
      $fatal(1, "schedule overflow");
    end
    r = (rst_off > 0) ? ((s + rst_off < e) ? s + rst_off : e) : fin + 100;
    for (int k = base; k <= fin + 1; k++) begin
      st_fa[k] = (k >= s && k < e);
      st_rst[k] = (k >= r && k < r + 3);
      st_rv[k] = 1'b0;
      st_rb[k] = 8'h00;
      exp_wr[k] = 0; exp_rd[k] = 0; exp_ld[k] = 0; chk_st[k] = 0; exp_rst[k] = 0;
    end
    // bytes while no frame is open must be ignored
    st_rv[base] = 1'b1; st_rb[base] = 8'($urandom);
    st_rv[e + 2] = 1'b1; st_rb[e + 2] = 8'($urandom);
    for (int k = 0; k <= n; k++) begin
      if (bc[k] < r) begin
        st_rv[bc[k]] = 1'b1;
        st_rb[bc[k]] = (k == 0) ? cmd : fdat[k-1];
      end
    end

    exp_ld[s] = 1; exp_tx[s] = 8'hA5;
    chk_st[s+1] = 1; exp_cnt[s+1] = 0; exp_err[s+1] = 0;
    a = int'(cmd[3:0]);
    cnt = 0;
    err = 0;
    if (!cmd[7]) begin
      for (int k = 1; k <= n; k++) begin
        if (bc[k] < r) begin
          exp_wr[bc[k]] = 1; exp_wa[bc[k]] = 4'(a); exp_wd[bc[k]] = fdat[k-1];
          exp_ld[bc[k]] = 1; exp_tx[bc[k]] = fdat[k-1];
          model_mem[a] = fdat[k-1];
          a = (a + 1) % 16;
          cnt = (cnt < 255) ? cnt + 1 : 255;
        end
      end
    end else begin
      t = bc[0];
      i = 1;
      while (1) begin
        if (t < e) begin
          exp_rd[t+1] = 1; exp_ra[t+1] = 4'(a);
          if (t + 2 <= e) begin
            exp_ld[t+2] = 1; exp_tx[t+2] = model_mem[a];
            a = (a + 1) % 16;
          end
        end
        while (i <= n && bc[i] <= t + 2) begin
          err = 1;
          i++;
        end
        if (i > n) break;
        t = bc[i];
        cnt = (cnt < 255) ? cnt + 1 : 255;
        i++;
      end
    end
    for (int k = e + 1; k <= fin; k++) begin
      chk_st[k] = 1; exp_cnt[k] = 8'(cnt); exp_err[k] = err;
    end
    if (rst_off > 0) begin
      for (int k = r; k <= fin + 1; k++) begin
        exp_wr[k] = 0; exp_rd[k] = 0; exp_ld[k] = 0;
        chk_st[k] = 1; exp_cnt[k] = 0; exp_err[k] = 0;
        exp_rst[k] = (k < r + 3);
      end
    end
    step_to(fin);
  endtask

  initial begin
    int w0, r0, t0, f0, f70, n, cg, ro;
    bit [7:0] cmd;
    rst_n = 1'b0;
    frame_active = 1'b0;
    rx_valid = 1'b0;
    rx_byte = 8'h00;
    for (int k = 0; k < 4; k++) begin
      st_rst[k] = 1;
      exp_rst[k] = 1;
      chk_st[k] = 1;
    end
    step_to(6);

    // 1: write 11@3, 22@4 back to back, echoed on tx_load
    w0 = wr_cnt; t0 = tx_log.size();
    fdat[0] = 8'h11; fdat[1] = 8'h22;
    fgap[0] = 1; fgap[1] = 1; fgap[2] = 1;
    do_frame(8'h03, 2, 1, 0);
    chk("t1_mem3", 32'(mem[3]), 32'h11);
    chk("t1_mem4", 32'(mem[4]), 32'h22);
    chk("t1_cnt", 32'(byte_cnt), 32'd2);
    chk("t1_writes", 32'(wr_cnt - w0), 32'd2);
    chk("t1_echo", 32'(tx_log[t0+2]), 32'h22);

    // 2: read from 15 with wrap to 0
    preload(4'hF, 8'h5A);
    preload(4'h0, 8'hC3);
    r0 = rd_cnt; t0 = tx_log.size();
    fgap[0] = 1; fgap[1] = 3; fgap[2] = 3;
    do_frame(8'h8F, 2, 3, 0);
    chk("t2_tx0", 32'(tx_log[t0]), 32'hA5);
    chk("t2_tx1", 32'(tx_log[t0+1]), 32'h5A);
    chk("t2_tx2", 32'(tx_log[t0+2]), 32'hC3);
    chk("t2_reads", 32'(rd_cnt - r0), 32'd3);

    // 3: byte during fetch is dropped and flagged
    r0 = rd_cnt;
    fdat[0] = 8'h00; fdat[1] = 8'h00;
    fgap[0] = 1; fgap[1] = 4; fgap[2] = 1;
    do_frame(8'h81, 2, 3, 0);
    chk("t3_err", 32'(err_ovr), 32'd1);
    chk("t3_reads", 32'(rd_cnt - r0), 32'd2);
    chk("t3_cnt", 32'(byte_cnt), 32'd1);

    // 4: command only, no side effects; err cleared by the new frame
    w0 = wr_cnt;
    fgap[0] = 1;
    do_frame(8'h02, 0, 1, 0);
    chk("t4_writes", 32'(wr_cnt - w0), 32'd0);
    chk("t4_err", 32'(err_ovr), 32'd0);

    // 5: reset in the middle of a write frame
    w0 = wr_cnt;
    for (int k = 0; k < 4; k++) fdat[k] = 8'(8'h40 + k);
    fgap[0] = 1; fgap[1] = 2; fgap[2] = 2; fgap[3] = 2; fgap[4] = 2;
    do_frame(8'h05, 4, 2, 6);
    chk("t5_writes", 32'(wr_cnt - w0), 32'd2);
    chk("t5_cnt", 32'(byte_cnt), 32'd0);

    // 6: fixed-address instance writes everything to 7
    f0 = fix_wr; f70 = fix_wr7;
    fdat[0] = 8'hA1; fdat[1] = 8'hB2; fdat[2] = 8'hC3;
    fgap[0] = 1; fgap[1] = 2; fgap[2] = 1; fgap[3] = 3;
    do_frame(8'h07, 3, 1, 0);
    chk("t6_fix_writes", 32'(fix_wr - f0), 32'd3);
    chk("t6_fix_at7", 32'(fix_wr7 - f70), 32'd3);
    chk("t6_fix_cnt", 32'(fix_cnt), 32'd3);
    chk("t6_main_mem9", 32'(mem[9]), 32'hC3);

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      cmd = 8'($urandom);
      n = int'($urandom_range(0, 6));
      for (int k = 0; k < 8; k++) begin
        fdat[k] = 8'($urandom);
        fgap[k] = int'($urandom_range(1, cmd[7] ? 5 : 3));
      end
      cg = int'($urandom_range(0, 3));
      ro = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 12)) : 0;
      do_frame(cmd, n, cg, ro);
    end

    step_to(cyc + 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
